dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states per access (legal range 1..15).
REQ-003 SHALL have port clk  input  1  the one clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port addr  input  32  byte address from the core data port.
REQ-006 SHALL have port din  input  32  store data, right-aligned.
REQ-007 SHALL have port read  input  1  load request.
REQ-008 SHALL have port write  input  1  store request.
REQ-009 SHALL have port size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-010 SHALL have port sign  input  1  1 = zero-extend (unsigned load), 0 = sign-extend.
REQ-011 SHALL have port dout  output  32  load data, right-aligned and extended.
REQ-012 SHALL have port valid  output  1  ready/complete; low stalls the core.
REQ-013 SHALL have port err  output  1  access fault, qualified by valid in RESP.

Function
REQ-014 SHALL implement the states IDLE, WAIT and RESP.
REQ-015 IDLE: valid SHALL be 1 when read=write=0, and 0 combinationally in the same cycle when read or write is 1.
REQ-016 IDLE with a request: on the next edge, SHALL latch addr, din, size, sign and the operation, load a wait counter with WAIT_CYCLES-1, and go to WAIT.
REQ-017 WAIT: valid=0; the counter SHALL decrement each cycle; at counter 0 the next edge SHALL go to RESP, commit any store, and register any load data.
REQ-018 RESP: valid=1 for exactly one cycle with dout/err valid; the next edge SHALL go to IDLE.
REQ-019 Latency: request first seen in cycle 0 -> valid low cycles 0..WAIT_CYCLES, high in cycle WAIT_CYCLES+1.
REQ-020 Request inputs SHALL be sampled only in IDLE; changes during WAIT/RESP SHALL be ignored.
REQ-021 A request present in the cycle after RESP SHALL be treated as a new access.
REQ-022 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored (wrap).
REQ-023 Store lanes: byte -> lane addr[1:0] from din[7:0]; half -> lanes by addr[1] from din[15:0]; word -> all lanes; other lanes SHALL stay unchanged.
REQ-024 Load: selected byte/half SHALL be extended to 32 bits per sign; a word SHALL be passed through.
REQ-025 read and write both 1 SHALL be treated as a store, with dout=0 in RESP.
REQ-026 dout SHALL be 0 in every cycle except RESP of a load.
REQ-027 size=11 SHALL be treated as word when STARFISH_DMEM_ERR_EN is undefined.

Reset
REQ-028 rst=1 SHALL force state=IDLE, counter=0, dout=0, err=0, with valid following REQ-015.
REQ-029 rst during WAIT SHALL abort the access; a pending store SHALL not be written.
REQ-030 Storage contents SHALL not be cleared by reset.

Configuration
REQ-031 With STARFISH_DMEM_ERR_EN defined: a misaligned access (half with addr[0]=1, word with addr[1:0]!=0) or size=11 SHALL assert err=1 in RESP, suppress the store, and force dout=0; timing SHALL be unchanged.
REQ-032 Without STARFISH_DMEM_ERR_EN: err SHALL be tied 0; misaligned half/word accesses SHALL use the aligned-down lanes.

Verification
REQ-033 Word store at 0x10 of 0xDEADBEEF, then word load at 0x10 (WAIT_CYCLES=2) -> valid low 3 cycles then high 1 cycle, dout=0xDEADBEEF.
REQ-034 Byte store of 0x80 to 0x13, then byte loads at 0x13 with sign=0 and sign=1 -> dout=0xFFFFFF80, then 0x00000080; word at 0x10 -> 0x80ADBEEF.
REQ-035 rst pulse during WAIT of a word store of 0x12345678 to 0x20 -> state IDLE, valid=1; a later load at 0x20 returns the prior contents.
REQ-036 Half load at 0x11 with STARFISH_DMEM_ERR_EN defined -> err=1, dout=0 in RESP; with the macro undefined -> err=0, data from lanes 0-1.
REQ-037 Address 4*DEPTH_WORDS+0x10 load -> returns the same word as address 0x10 (wrap).
REQ-038 read=write=0 held for 10 cycles -> valid=1 throughout and dout=0.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated data memory responder for a core data port
// Optional fault reporting (misaligned/reserved size) enabled by STARFISH_DMEM_ERR_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic        read,
    input  logic        write,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] dout,
    output logic        valid,
    output logic        err
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int AW = IW + 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   din_q, din_d;
    logic [31:0]   dout_q, dout_d;
    logic [1:0]    size_q, size_d;
    logic          sign_q, sign_d;
    logic          store_q, store_d;
`ifdef STARFISH_DMEM_ERR_EN
    logic          err_q, err_d;
`endif

    logic [31:0]   mem [DEPTH_WORDS];
    logic [IW-1:0] widx;
    logic [31:0]   rdata, wdata, ldata;
    logic [3:0]    be;
    logic [7:0]    bsel;
    logic [15:0]   hsel;
    logic          fault;
    logic          mem_we;
    logic          unused_addr;

    assign unused_addr = &{1'b0, addr[31:AW]};
    assign widx  = addr_q[AW-1:2];
    assign rdata = mem[widx];
    assign dout  = dout_q;

`ifdef STARFISH_DMEM_ERR_EN
    assign fault = (size_q == 2'b11)
                || (size_q == 2'b01 && addr_q[0])
                || (size_q == 2'b10 && addr_q[1:0] != 2'b00);
    assign err   = err_q;
`else
    assign fault = 1'b0;
    assign err   = 1'b0;
`endif

    // Lane steering; size 11 falls through to word handling.
    always_comb begin
        be    = 4'b1111;
        wdata = din_q;
        case (addr_q[1:0])
            2'd0:    bsel = rdata[7:0];
            2'd1:    bsel = rdata[15:8];
            2'd2:    bsel = rdata[23:16];
            default: bsel = rdata[31:24];
        endcase
        hsel = addr_q[1] ? rdata[31:16] : rdata[15:0];
        ldata = rdata;
        case (size_q)
            2'b00: begin
                be    = 4'b0001 << addr_q[1:0];
                wdata = {4{din_q[7:0]}};
                ldata = sign_q ? {24'b0, bsel} : {{24{bsel[7]}}, bsel};
            end
            2'b01: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata = {2{din_q[15:0]}};
                ldata = sign_q ? {16'b0, hsel} : {{16{hsel[15]}}, hsel};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        size_d  = size_q;
        sign_d  = sign_q;
        store_d = store_q;
        dout_d  = 32'b0;
`ifdef STARFISH_DMEM_ERR_EN
        err_d   = 1'b0;
`endif
        valid   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                valid = !(read || write);
                if (read || write) begin
                    addr_d  = addr[AW-1:0];
                    din_d   = din;
                    size_d  = size;
                    sign_d  = sign;
                    store_d = write;
                    cnt_d   = 4'(WAIT_CYCLES - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    mem_we  = store_q && !fault;
                    if (!store_q && !fault) begin
                        dout_d = ldata;
                    end
`ifdef STARFISH_DMEM_ERR_EN
                    err_d = fault;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                valid   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            din_q   <= 32'b0;
            size_q  <= 2'b0;
            sign_q  <= 1'b0;
            store_q <= 1'b0;
            dout_q  <= 32'b0;
`ifdef STARFISH_DMEM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            store_q <= store_d;
            dout_q  <= dout_d;
`ifdef STARFISH_DMEM_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // Storage is never reset; a store aborted by rst must not land.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - table and scoreboard bench for dmem_responder
module tb_dmem_responder;
    localparam int DEPTH = 1024;
    localparam int WAITC = 2;
`ifdef STARFISH_DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'b0;
    logic [31:0] din = 32'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [1:0]  size = 2'b0;
    logic        sign = 1'b0;
    logic [31:0] dout;
    logic        valid;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [1:0]  size;
        bit          sign;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst), .addr(addr), .din(din), .read(read), .write(write),
        .size(size), .sign(sign), .dout(dout), .valid(valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] ed, input bit ee);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = sz; v.sign = sg;
        v.addr = a; v.din = d; v.exp_dout = ed; v.exp_err = ee;
        return v;
    endfunction

    task automatic run_access(input vec_t v, input int idx);
        bit   done;
        exp_t e;
        sb.push_back('{d: v.exp_dout, e: v.exp_err});
        @(negedge clk);
        read = v.rd; write = v.wr; size = v.size; sign = v.sign; addr = v.addr; din = v.din;
        #1 check($sformatf("v%0d req_valid", idx), {31'b0, valid}, 32'd0);
        done = 1'b0;
        for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                read = 1'b0; write = 1'b0;
                addr = $urandom; din = $urandom;
                size = 2'($urandom_range(0, 3)); sign = 1'($urandom_range(0, 1));
            end
            #1;
            if (valid) begin
                done = 1'b1;
                e = sb.pop_front();
                check($sformatf("v%0d latency", idx), cyc, WAITC + 1);
                check($sformatf("v%0d dout", idx), dout, e.d);
                check($sformatf("v%0d err", idx), {31'b0, err}, {31'b0, e.e});
            end else begin
                check($sformatf("v%0d wait_dout", idx), dout, 32'd0);
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL v%0d timeout: valid never rose within 20 cycles", idx);
            void'(sb.pop_front());
        end
        @(negedge clk);
        #1 check($sformatf("v%0d idle_valid", idx), {31'b0, valid}, 32'd1);
        check($sformatf("v%0d idle_dout", idx), dout, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back(mk(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0));
        tbl.push_back(mk(1, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 1, 2'd0, 0, 32'h13, 32'hAB123480, 32'h0, 0));
        tbl.push_back(mk(1, 0, 2'd0, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0));
        tbl.push_back(mk(1, 0, 2'd0, 1, 32'h13, 32'h0, 32'h00000080, 0));
        tbl.push_back(mk(1, 0, 2'd2, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0));
        tbl.push_back(mk(1, 0, 2'd2, 0, 32'(4*DEPTH + 16), 32'h0, 32'h80ADBEEF, 0));
        tbl.push_back(mk(0, 1, 2'd2, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0));
        tbl.push_back(mk(0, 1, 2'd1, 0, 32'h22, 32'h1234ABCD, 32'h0, 0));
        tbl.push_back(mk(1, 0, 2'd1, 0, 32'h22, 32'h0, 32'hFFFFABCD, 0));
        tbl.push_back(mk(1, 0, 2'd1, 1, 32'h20, 32'h0, 32'h0000F00D, 0));
        tbl.push_back(mk(1, 0, 2'd1, 1, 32'h11, 32'h0, ERR_EN ? 32'h0 : 32'h0000BEEF, ERR_EN));
        tbl.push_back(mk(1, 1, 2'd2, 0, 32'h24, 32'h55AA55AA, 32'h0, 0));
        tbl.push_back(mk(1, 0, 2'd2, 0, 32'h24, 32'h0, 32'h55AA55AA, 0));
        tbl.push_back(mk(1, 0, 2'd3, 0, 32'h24, 32'h0, ERR_EN ? 32'h0 : 32'h55AA55AA, ERR_EN));
        tbl.push_back(mk(0, 1, 2'd2, 0, 32'h25, 32'h11111111, 32'h0, ERR_EN));
        tbl.push_back(mk(1, 0, 2'd2, 0, 32'h24, 32'h0, ERR_EN ? 32'h55AA55AA : 32'h11111111, 0));
        tbl.push_back(mk(1, 0, 2'd0, 0, 32'h21, 32'h0, 32'hFFFFFFF0, 0));
        tbl.push_back(mk(0, 1, 2'd2, 0, 32'h2C, 32'h0, 32'h0, 0));
        tbl.push_back(mk(0, 1, 2'd0, 0, 32'hABCDE02E, 32'h99, 32'h0, 0));
        tbl.push_back(mk(1, 0, 2'd2, 0, 32'h2C, 32'h0, 32'h00990000, 0));

        repeat (2) @(negedge clk);
        #1 check("rst_valid", {31'b0, valid}, 32'd1);
        check("rst_dout", dout, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run_access(tbl[i], i);
        end

        // Request held across RESP is taken as a fresh access.
        @(negedge clk);
        read = 1'b1; write = 1'b0; size = 2'd2; sign = 1'b0; addr = 32'h10;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #1 check($sformatf("b2b valid c%0d", k), {31'b0, valid}, (k == 3 || k == 7) ? 32'd1 : 32'd0);
            check($sformatf("b2b dout c%0d", k), dout, (k == 3 || k == 7) ? 32'h80ADBEEF : 32'd0);
        end
        @(negedge clk);
        read = 1'b0;

        // Reset in the last wait cycle aborts a pending store.
        @(negedge clk);
        write = 1'b1; size = 2'd2; addr = 32'h20; din = 32'h12345678;
        @(negedge clk);
        write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 check("abort_valid", {31'b0, valid}, 32'd1);
        check("abort_dout", dout, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("abort_idle_valid", {31'b0, valid}, 32'd1);
        run_access(mk(1, 0, 2'd2, 0, 32'h20, 32'h0, 32'hABCDF00D, 0), 100);

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1 check($sformatf("idle valid c%0d", k), {31'b0, valid}, 32'd1);
            check($sformatf("idle dout c%0d", k), dout, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
